// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  // Sequencer states: normal flow, multi-cycle EX op in progress, post-flush bubble cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MULTI = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  // Stall vector bit order: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]reserved.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_1180;

  // Merge ID/EX stall requests; an EX stall also covers everything an ID stall holds.
  function automatic logic [5:0] stall_from_req(input logic req_ex, input logic req_id);
    logic [5:0] s;
    if (req_ex) begin
      s = STALL_EX;
    end else if (req_id) begin
      s = STALL_ID;
    end else begin
      s = STALL_NONE;
    end
    return s;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_multi_cycle_timer.sv
// Countdown for multi-cycle EX operations. Loaded with MULTI_CYCLES-2 on the start
// cycle so that the zero count lands on the cycle the EX result becomes valid.
module pipeline_ctrl_multi_cycle_timer
  import pipeline_ctrl_pkg::*;
#(
  parameter int MULTI_CYCLES = 34,
  parameter int CNT_W        = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic cancel_i,
  input  logic run_i,
  output logic done_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MULTI_CYCLES - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: cancel clears, load arms, otherwise count down without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (cancel_i) begin
      cnt_d = CNT_ZERO;
    end else if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (run_i && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = run_i && (cnt_q == CNT_ZERO);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Outputs are combinational
// from inputs and state so the pipeline registers react in the requesting cycle.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int          MULTI_CYCLES = 34,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int          CNT_W        = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        ex_multi_start,
  input  logic        ex_multi_cancel,
  input  logic        exc_valid,
  input  logic        exc_is_eret,
  input  logic [31:0] epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        multi_busy,
  output logic        multi_done
);

  state_e state_q;
  state_e state_d;
  logic   tmr_load_s;
  logic   tmr_cancel_s;
  logic   tmr_run_s;
  logic   tmr_done_s;

  assign tmr_run_s = (state_q == ST_MULTI);

  pipeline_ctrl_multi_cycle_timer #(
    .MULTI_CYCLES (MULTI_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load_s),
    .cancel_i (tmr_cancel_s),
    .run_i    (tmr_run_s),
    .done_o   (tmr_done_s)
  );

  // Next state and outputs: reset forces zeros, exceptions override everything else.
  always_comb begin
    state_d      = state_q;
    stall        = STALL_NONE;
    flush        = 1'b0;
    new_pc       = 32'h0000_0000;
    multi_busy   = 1'b0;
    multi_done   = 1'b0;
    tmr_load_s   = 1'b0;
    tmr_cancel_s = 1'b0;
    if (rst) begin
      state_d = ST_IDLE;
    end else if (exc_valid) begin
      // Exception/ERET aborts any multi-cycle op and flushes without stalling.
      flush        = 1'b1;
      new_pc       = exc_is_eret ? epc_i : EXC_VECTOR;
      tmr_cancel_s = 1'b1;
      state_d      = ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ex_multi_start) begin
            stall      = STALL_EX;
            multi_busy = 1'b1;
            tmr_load_s = 1'b1;
            state_d    = ST_MULTI;
          end else begin
            stall = stall_from_req(stallreq_ex, stallreq_id);
          end
        end
        ST_MULTI: begin
          if (ex_multi_cancel) begin
            stall        = stall_from_req(stallreq_ex, stallreq_id);
            tmr_cancel_s = 1'b1;
            state_d      = ST_IDLE;
          end else if (tmr_done_s) begin
            // Result ready: release EX so it can write EX/MEM; only an ID hazard still holds.
            multi_done = 1'b1;
            multi_busy = 1'b1;
            stall      = stallreq_id ? STALL_ID : STALL_NONE;
            state_d    = ST_IDLE;
          end else begin
            stall      = STALL_EX;
            multi_busy = 1'b1;
          end
        end
        ST_FLUSH: begin
          // EX holds a bubble after a flush, so a start request here is dropped.
          stall   = stall_from_req(stallreq_ex, stallreq_id);
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
